// File: rtl/mutex_merge5_rr_arb_pkg.sv
// Shared definitions for the five-input mutex merge arbiter: sizes, FSM
// state encoding and a one-hot to index helper.
package mutex_merge5_rr_arb_pkg;

  localparam int N_IN  = 5;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_IN-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mutex_merge5_rr_arb_rr_pick5.sv
// Combinational round-robin picker: first asserted request found searching
// upward from the slot after the previous winner, wrapping at five.
module rr_pick5
  import mutex_merge5_rr_arb_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = N_IN; off >= 1; off--) begin
      cand = IDX_W'((int'(last) + off) % N_IN);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mutex_merge5_rr_arb.sv
// Five-way four-phase handshake merge with round-robin arbitration and a
// registered payload/grant toward a single downstream port.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no owner; arbitrate among pending requests
// ST_BUSY    | o_driveNext high, waiting for i_freeNext
// ST_RELEASE | o_free_g high, waiting for i_drive_g and i_freeNext to fall
module mutex_merge5_rr_arb
  import mutex_merge5_rr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive0,
  input  logic                  i_drive1,
  input  logic                  i_drive2,
  input  logic                  i_drive3,
  input  logic                  i_drive4,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [DATA_WIDTH-1:0] i_data3,
  input  logic [DATA_WIDTH-1:0] i_data4,
  output logic                  o_free0,
  output logic                  o_free1,
  output logic                  o_free2,
  output logic                  o_free3,
  output logic                  o_free4,
  output logic                  o_driveNext,
  input  logic                  i_freeNext,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [N_IN-1:0]       o_grant,
  output logic [CNT_WIDTH-1:0]  o_txCount
);

  state_t                state;
  logic [N_IN-1:0]       drive_vec;
  logic [DATA_WIDTH-1:0] data_arr [N_IN];
  logic [N_IN-1:0]       free_q;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      g_idx;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  assign drive_vec   = {i_drive4, i_drive3, i_drive2, i_drive1, i_drive0};
  assign data_arr[0] = i_data0;
  assign data_arr[1] = i_data1;
  assign data_arr[2] = i_data2;
  assign data_arr[3] = i_data3;
  assign data_arr[4] = i_data4;

  assign {o_free4, o_free3, o_free2, o_free1, o_free0} = free_q;
  assign g_idx = onehot_to_idx(o_grant);

  rr_pick5 u_pick (
    .req   (drive_vec),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      o_driveNext <= 1'b0;
      free_q      <= '0;
      o_grant     <= '0;
      o_data      <= '0;
      o_txCount   <= '0;
      last_grant  <= IDX_W'(N_IN - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state       <= ST_BUSY;
            o_data      <= data_arr[pick_idx];
            o_grant     <= N_IN'(1) << pick_idx;
            o_driveNext <= 1'b1;
            last_grant  <= pick_idx;
          end
        end
        ST_BUSY: begin
          // The owner's request level is deliberately not watched here.
          if (i_freeNext) begin
            state       <= ST_RELEASE;
            o_driveNext <= 1'b0;
            free_q      <= N_IN'(1) << g_idx;
            o_txCount   <= o_txCount + CNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (!drive_vec[g_idx] && !i_freeNext) begin
            state   <= ST_IDLE;
            free_q  <= '0;
            o_grant <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_merge5_rr_arb.sv
// Self-checking bench for mutex_merge5_rr_arb: requesters and downstream
// are driven procedurally, expected owner/payload flow through a queue.
module tb_mutex_merge5_rr_arb;

  localparam int DW = 128;
  localparam int CW = 4;

  typedef struct {
    int           g;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    drv = '0;
  logic [DW-1:0] dat [5];
  logic          i_freeNext = 1'b0;
  logic          o_free0, o_free1, o_free2, o_free3, o_free4;
  logic          o_driveNext;
  logic [DW-1:0] o_data;
  logic [4:0]    o_grant;
  logic [CW-1:0] o_txCount;
  logic [4:0]    free_vec;

  exp_t          sb [$];
  logic [CW-1:0] tx_exp = '0;
  int            n_checks = 0;
  int            n_pass = 0;

  assign free_vec = {o_free4, o_free3, o_free2, o_free1, o_free0};

  always #5 clk = ~clk;

  mutex_merge5_rr_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive0    (drv[0]),
    .i_drive1    (drv[1]),
    .i_drive2    (drv[2]),
    .i_drive3    (drv[3]),
    .i_drive4    (drv[4]),
    .i_data0     (dat[0]),
    .i_data1     (dat[1]),
    .i_data2     (dat[2]),
    .i_data3     (dat[3]),
    .i_data4     (dat[4]),
    .o_free0     (o_free0),
    .o_free1     (o_free1),
    .o_free2     (o_free2),
    .o_free3     (o_free3),
    .o_free4     (o_free4),
    .o_driveNext (o_driveNext),
    .i_freeNext  (i_freeNext),
    .o_data      (o_data),
    .o_grant     (o_grant),
    .o_txCount   (o_txCount)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_drv"},   o_driveNext, 0);
    check({tag, "_free"},  free_vec, 0);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_data"},  o_data, 0);
    check({tag, "_tx"},    o_txCount, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    rst    = 1'b1;
    tx_exp = '0;
  endtask

  task automatic push(input int g);
    exp_t e;
    e.g = g;
    e.d = dat[g];
    sb.push_back(e);
  endtask

  // Downstream side of one transfer; hold keeps i_freeNext high in RELEASE.
  task automatic serve(input int hold, input bit redrive, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!o_driveNext && n < 20) begin
      step();
      n++;
    end
    if (!o_driveNext) begin
      check("drv_timeout", o_driveNext, 1);
      return;
    end
    if (exp_lat >= 0) check("req_lat", n, exp_lat);
    if (sb.size() == 0) begin
      check("sb_empty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("grant", o_grant, 5'(1) << e.g);
    check("data", o_data, e.d);
    i_freeNext = 1'b1;
    step();
    tx_exp++;
    check("free_on", free_vec, 5'(1) << e.g);
    check("drv_off", o_driveNext, 0);
    check("txcount", o_txCount, tx_exp);
    for (int i = 0; i < hold; i++) begin
      step();
      check("free_hold", free_vec, 5'(1) << e.g);
      check("no_redrive", o_driveNext, 0);
    end
    drv[e.g]   = 1'b0;
    i_freeNext = 1'b0;
    step();
    check("free_off", free_vec, 0);
    check("grant_clr", o_grant, 0);
    if (redrive) drv[e.g] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 5; k++) dat[k] = DW'(32'h1000 + k);
    do_reset();

    // Downstream acknowledge while idle must be ignored.
    i_freeNext = 1'b1;
    step();
    step();
    check("idle_free_drv", o_driveNext, 0);
    check("idle_free_out", free_vec, 0);
    i_freeNext = 1'b0;
    step();

    // Single request on port 2.
    dat[2] = DW'(8'hA5);
    drv[2] = 1'b1;
    push(2);
    serve(0, 0, 1);

    // Make 1 the last winner, then 1 and 3 together: 3 first.
    drv[1] = 1'b1;
    push(1);
    serve(0, 0, -1);
    drv[1] = 1'b1;
    drv[3] = 1'b1;
    push(3);
    push(1);
    serve(0, 0, -1);
    serve(0, 0, -1);

    // Downstream acknowledge lingering in RELEASE.
    drv[0] = 1'b1;
    push(0);
    serve(3, 0, -1);

    // Owner drops its request mid-BUSY; transfer still completes.
    drv[4] = 1'b1;
    push(4);
    step();
    step();
    drv[4] = 1'b0;
    serve(0, 0, -1);

    // Five continuous requesters after reset.
    do_reset();
    for (int k = 0; k < 5; k++) dat[k] = {$urandom, $urandom, $urandom, $urandom};
    drv = 5'h1f;
    push(0); push(1); push(2); push(3); push(4); push(0);
    for (int i = 0; i < 5; i++) serve(0, 1, -1);
    serve(0, 0, -1);
    drv = '0;
    check("tx_six", o_txCount, 4'd6);
    repeat (3) step();
    check("data_persist", o_data, dat[0]);

    // Reset during BUSY, with another request pending.
    drv[3] = 1'b1;
    for (int n = 0; n < 10 && !o_driveNext; n++) step();
    check("busy_grant3", o_grant, 5'b01000);
    drv[1] = 1'b1;
    rst = 1'b0;
    step();
    check_idle_outputs("midrst");
    rst    = 1'b1;
    tx_exp = '0;
    push(1);
    push(3);
    serve(0, 0, -1);
    serve(0, 0, -1);

    // Counter wrap over 16 transfers.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      int k;
      k      = $urandom_range(0, 4);
      dat[k] = {$urandom, $urandom, $urandom, $urandom};
      drv[k] = 1'b1;
      push(k);
      serve(0, 0, -1);
    end
    check("tx_wrap", o_txCount, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
